// File: rtl/m_add_seq_pkg.sv
`default_nettype none
// ============================================================================
//  m_add_seq_pkg
//  Shared constants and state encoding for the multi-word add sequencer.
//  Revision: 1.0
// ============================================================================
package m_add_seq_pkg;

  localparam int unsigned c_D_N   = 5;
  localparam int unsigned c_WORDS = 4;
  localparam int unsigned c_IDX_W = $clog2(c_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/m_add_seq_slice.sv
`default_nettype none
// ============================================================================
//  m_add_slice
//  D_N-bit ripple-carry adder slice with carry-in and carry-out.
//  Revision: 1.0
// ============================================================================
module m_add_slice
  import m_add_seq_pkg::*;
#(
  parameter int unsigned D_N = c_D_N
) (
  input  logic [D_N-1:0] w_a,
  input  logic [D_N-1:0] w_b,
  input  logic           w_cin,
  output logic [D_N-1:0] w_s,
  output logic           w_cout
);

  logic [D_N:0] w_c;

  assign w_c[0] = w_cin;

  for (genvar i = 0; i < D_N; i++) begin : g_fa
    assign w_s[i]   = w_a[i] ^ w_b[i] ^ w_c[i];
    assign w_c[i+1] = (w_a[i] & w_b[i]) | (w_c[i] & (w_a[i] ^ w_b[i]));
  end

  assign w_cout = w_c[D_N];

endmodule
`default_nettype wire

// File: rtl/m_add_seq.sv
`default_nettype none
// ============================================================================
//  m_add_seq
//  Round-robin arbiter sharing one adder slice to perform multi-word adds.
//  Revision: 1.0
// ============================================================================
module m_add_seq
  import m_add_seq_pkg::*;
#(
  parameter int unsigned D_N   = c_D_N,
  parameter int unsigned WORDS = c_WORDS
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic [1:0]           w_req,
  input  logic [D_N*WORDS-1:0] w_a0,
  input  logic [D_N*WORDS-1:0] w_b0,
  input  logic [D_N*WORDS-1:0] w_a1,
  input  logic [D_N*WORDS-1:0] w_b1,
  output logic [1:0]           w_gnt,
  output logic [1:0]           w_done,
  output logic [D_N*WORDS-1:0] w_sum,
  output logic                 w_cout,
  output logic                 w_busy
);

  localparam int unsigned     W      = D_N * WORDS;
  localparam int unsigned     IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(WORDS - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_ptr;
  logic             r_own;
  logic             r_c;
  logic             r_cout;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;

  logic             w_sel_vld;
  logic             w_sel;
  logic             w_last;
  logic [D_N-1:0]   w_wa;
  logic [D_N-1:0]   w_wb;
  logic [D_N-1:0]   w_ws;
  logic             w_wc;

  // A lone request wins outright; the pointer only breaks ties.
  assign w_sel_vld = |w_req;
  assign w_sel     = (w_req == 2'b11) ? r_ptr : w_req[1];
  assign w_last    = (r_idx == c_LAST);

  assign w_wa = r_a[r_idx*D_N +: D_N];
  assign w_wb = r_b[r_idx*D_N +: D_N];

  m_add_slice #(
    .D_N (D_N)
  ) u_slice (
    .w_a    (w_wa),
    .w_b    (w_wb),
    .w_cin  (r_c),
    .w_s    (w_ws),
    .w_cout (w_wc)
  );

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_sel_vld) w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_ptr  <= 1'b0;
      r_own  <= 1'b0;
      r_c    <= 1'b0;
      r_cout <= 1'b0;
      r_idx  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sel_vld) begin
            r_own <= w_sel;
            r_ptr <= ~w_sel;
            r_idx <= '0;
            r_c   <= 1'b0;
            r_a   <= w_sel ? w_a1 : w_a0;
            r_b   <= w_sel ? w_b1 : w_b0;
          end
        end
        RUN: begin
          r_sum[r_idx*D_N +: D_N] <= w_ws;
          r_c                     <= w_wc;
          r_idx                   <= r_idx + IDX_W'(1);
          // Final carry is published only once the top word is known.
          if (w_last) r_cout <= w_wc;
        end
        default: ;
      endcase
    end
  end

  assign w_busy = (r_state != IDLE);
  assign w_gnt  = (r_state == RUN && r_idx == '0) ? {r_own, ~r_own} : 2'b00;
  assign w_done = (r_state == DONE) ? {r_own, ~r_own} : 2'b00;
  assign w_sum  = r_sum;
  assign w_cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_m_add_seq.sv
`default_nettype none
// ============================================================================
//  tb_m_add_seq
//  Self-checking bench: directed scenarios plus randomized requests.
//  Revision: 1.0
// ============================================================================
module tb_m_add_seq;

  localparam int D_N   = 5;
  localparam int WORDS = 4;
  localparam int W     = D_N * WORDS;

  logic         w_clk = 1'b0;
  logic         w_rst;
  logic [1:0]   w_req;
  logic [W-1:0] w_a0, w_b0, w_a1, w_b1;
  logic [1:0]   w_gnt, w_done;
  logic [W-1:0] w_sum;
  logic         w_cout, w_busy;

  int n_vec = 0;
  int n_err = 0;
  int ptr_m = 0;

  m_add_seq #(.D_N(D_N), .WORDS(WORDS)) dut (
    .w_clk  (w_clk),
    .w_rst  (w_rst),
    .w_req  (w_req),
    .w_a0   (w_a0),
    .w_b0   (w_b0),
    .w_a1   (w_a1),
    .w_b1   (w_b1),
    .w_gnt  (w_gnt),
    .w_done (w_done),
    .w_sum  (w_sum),
    .w_cout (w_cout),
    .w_busy (w_busy)
  );

  always #5 w_clk = ~w_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  function automatic logic [1:0] oh(input int i);
    return (i != 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    v = W'($urandom);
    if ($urandom_range(0, 3) == 0) v = '1;
    return v;
  endfunction

  task automatic do_reset();
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
    ptr_m = 0;
  endtask

  // Serve one operation starting from IDLE with w_req already driven.
  task automatic serve(input bit raise_other, output int win);
    logic [W-1:0] a, b;
    logic [W:0]   r;
    int           oth;
    if (w_req == 2'b11) win = ptr_m;
    else                win = w_req[1] ? 1 : 0;
    oth = 1 - win;
    a = (win != 0) ? w_a1 : w_a0;
    b = (win != 0) ? w_b1 : w_b0;
    r = {1'b0, a} + {1'b0, b};

    tick();
    chk("gnt", 32'(w_gnt), 32'(oh(win)));
    chk("busy_at_gnt", 32'(w_busy), 32'd1);
    w_req[win] = 1'b0;
    ptr_m = oth;
    if (win != 0) begin
      w_a1 = rnd_op(); w_b1 = rnd_op();
    end else begin
      w_a0 = rnd_op(); w_b0 = rnd_op();
    end

    for (int k = 2; k <= WORDS; k++) begin
      tick();
      if (k == 2 && raise_other && !w_req[oth]) begin
        if (oth != 0) begin
          w_a1 = rnd_op(); w_b1 = rnd_op();
        end else begin
          w_a0 = rnd_op(); w_b0 = rnd_op();
        end
        w_req[oth] = 1'b1;
      end
      chk("gnt_in_run", 32'(w_gnt), 32'd0);
      chk("done_in_run", 32'(w_done), 32'd0);
      chk("busy_in_run", 32'(w_busy), 32'd1);
    end

    tick();
    chk("done", 32'(w_done), 32'(oh(win)));
    chk("sum", 32'(w_sum), 32'(r[W-1:0]));
    chk("cout", 32'(w_cout), 32'(r[W]));
    chk("busy_at_done", 32'(w_busy), 32'd1);
    chk("gnt_at_done", 32'(w_gnt), 32'd0);

    tick();
    chk("busy_idle", 32'(w_busy), 32'd0);
    chk("done_idle", 32'(w_done), 32'd0);
    chk("gnt_idle", 32'(w_gnt), 32'd0);
    chk("sum_held", 32'(w_sum), 32'(r[W-1:0]));
  endtask

  initial begin
    int win;
    int pat;
    int guard;

    w_rst = 1'b1;
    w_req = 2'b00;
    w_a0 = '0; w_b0 = '0; w_a1 = '0; w_b1 = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(w_gnt), 32'd0);
    chk("rst_done", 32'(w_done), 32'd0);
    chk("rst_sum", 32'(w_sum), 32'd0);
    chk("rst_cout", 32'(w_cout), 32'd0);
    chk("rst_busy", 32'(w_busy), 32'd0);
    w_rst = 1'b0;
    ptr_m = 0;
    tick();
    chk("idle_no_req", 32'(w_busy), 32'd0);

    // Basic add.
    w_a0 = 20'd321; w_b0 = 20'd4444; w_req = 2'b01;
    serve(1'b0, win);
    chk("basic_sum", 32'(w_sum), 32'd4765);

    // Carries between words and out of the top word.
    w_a0 = 20'd31; w_b0 = 20'd1; w_req = 2'b01;
    serve(1'b0, win);
    chk("carry_w0_w1", 32'(w_sum), 32'd32);
    w_a0 = 20'hFFFFF; w_b0 = 20'd1; w_req = 2'b01;
    serve(1'b0, win);
    chk("wrap_sum", 32'(w_sum), 32'd0);
    chk("wrap_cout", 32'(w_cout), 32'd1);

    // Simultaneous requests after reset.
    do_reset();
    w_a0 = 20'd1024; w_b0 = 20'd2048; w_a1 = 20'd5; w_b1 = 20'd6; w_req = 2'b11;
    serve(1'b0, win);
    chk("simul_first_sum", 32'(w_sum), 32'd3072);
    serve(1'b0, win);
    chk("simul_second_sum", 32'(w_sum), 32'd11);

    // Round-robin: both re-assert after every grant.
    for (int i = 0; i < 4; i++) begin
      w_a0 = rnd_op(); w_b0 = rnd_op(); w_a1 = rnd_op(); w_b1 = rnd_op();
      w_req = 2'b11;
      serve(1'b0, win);
      chk("rr_order", 32'(win), 32'(i % 2));
      w_req = 2'b00;
    end

    // Request arriving while busy.
    w_a0 = rnd_op(); w_b0 = rnd_op(); w_req = 2'b01;
    serve(1'b1, win);
    serve(1'b0, win);

    // Reset in the middle of an operation.
    w_a0 = 20'd100; w_b0 = 20'd200; w_req = 2'b01;
    tick();
    w_req = 2'b00;
    tick();
    tick();
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
    ptr_m = 0;
    chk("abort_done", 32'(w_done), 32'd0);
    chk("abort_sum", 32'(w_sum), 32'd0);
    chk("abort_busy", 32'(w_busy), 32'd0);
    chk("abort_cout", 32'(w_cout), 32'd0);
    w_a0 = 20'd7; w_b0 = 20'd8; w_req = 2'b01;
    serve(1'b0, win);
    chk("after_abort_sum", 32'(w_sum), 32'd15);

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      pat = $urandom_range(1, 3);
      if (pat[0]) begin w_a0 = rnd_op(); w_b0 = rnd_op(); end
      if (pat[1]) begin w_a1 = rnd_op(); w_b1 = rnd_op(); end
      w_req = 2'(pat);
      guard = 0;
      while (w_req != 2'b00 && guard < 3) begin
        serve((guard == 0) && ($urandom_range(0, 2) == 0), win);
        guard++;
      end
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
